// File: rtl/leb128_fetch.sv
// leb128_fetch: streams bytes from a registered ROM and decodes one WebAssembly LEB128 immediate.
module leb128_fetch #(
  parameter int MEM_DEPTH = 6,
  parameter bit USE_64B   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MEM_DEPTH:0]   addr_in,
  input  logic                 is_signed,
  input  logic                 is_64,
  output logic                 busy,
  output logic                 done,
  output logic [63:0]          value,
  output logic [3:0]           length,
  output logic [MEM_DEPTH:0]   next_addr,
  output logic [2:0]           error,
  output logic [MEM_DEPTH:0]   mem_addr,
  input  logic [7:0]           mem_data,
  input  logic                 mem_error
);
  typedef enum logic [1:0] {IDLE, FILL, DECODE, DONE} state_t;
  state_t state;
  logic [MEM_DEPTH:0] ptr;
  logic [63:0] acc, acc_n, ext, res;
  logic [3:0] count, len_n;
  logic sgn, w64, last, pad_ok;
  logic [2:0] err_n;
  assign busy = state != IDLE;
  assign mem_addr = ptr;
  always_comb begin
    last = count == (w64 ? 4'd9 : 4'd4);
    len_n = count + 4'd1;
    acc_n = acc | (64'(mem_data[6:0]) << (7 * count));
    pad_ok = w64 ? (sgn ? mem_data[6:1] == {6{mem_data[0]}} : mem_data[6:1] == 6'd0)
                 : (sgn ? (mem_data[6:3] == 4'h0 || mem_data[6:3] == 4'hF) : mem_data[6:4] == 3'd0);
    err_n = mem_error ? 3'd3 : (last && mem_data[7]) ? 3'd1 : (last && !pad_ok) ? 3'd2 : 3'd0;
    // shift of 70 for a 10-byte read yields zero, so no fill is applied there
    ext = acc_n | ((sgn && mem_data[6]) ? ~64'd0 << (7 * len_n) : 64'd0);
    res = w64 ? ext : sgn ? {{32{ext[31]}}, ext[31:0]} : {32'd0, ext[31:0]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      acc <= '0;
      count <= '0;
      sgn <= 1'b0;
      w64 <= 1'b0;
      done <= 1'b0;
      value <= '0;
      length <= '0;
      next_addr <= '0;
      error <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sgn <= is_signed;
            w64 <= is_64;
            if (is_64 && !USE_64B) begin
              state <= DONE;
              done <= 1'b1;
              error <= 3'd4;
              value <= '0;
              length <= '0;
              next_addr <= addr_in;
            end else begin
              ptr <= addr_in;
              acc <= '0;
              count <= '0;
              state <= FILL;
            end
          end
        end
        FILL: begin
          ptr <= ptr + 1'b1;
          state <= DECODE;
        end
        DECODE: begin
          ptr <= ptr + 1'b1;
          acc <= acc_n;
          count <= len_n;
          // ptr already points one past the byte on mem_data
          if (!mem_data[7] || err_n != 3'd0) begin
            state <= DONE;
            done <= 1'b1;
            value <= err_n != 3'd0 ? 64'd0 : res;
            length <= len_n;
            next_addr <= ptr;
            error <= err_n;
          end
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_leb128_fetch.sv
// tb_leb128_fetch: directed LEB128 vectors checked against a bench-side arithmetic decoder model.
module tb_leb128_fetch;
  localparam int ROM_SIZE = 100;
  logic clk = 1'b0;
  logic reset, start, start2, is_signed, is_64;
  logic [6:0] addr_in, mem_addr, next_addr, mem_addr2, next_addr2;
  logic busy, done, busy2, done2;
  logic [63:0] value, value2;
  logic [3:0] length, length2;
  logic [2:0] error, error2;
  logic [7:0] mem_data;
  logic mem_error;
  logic [7:0] rom [128];
  int checks = 0, failures = 0, cyc = 0, exp_lat = 0;
  bit pending = 0;
  logic [63:0] exp_v;
  logic [3:0] exp_l;
  logic [6:0] exp_na;
  logic [2:0] exp_e;

  always #5 clk = ~clk;

  leb128_fetch #(.MEM_DEPTH(6), .USE_64B(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .addr_in(addr_in), .is_signed(is_signed), .is_64(is_64),
    .busy(busy), .done(done), .value(value), .length(length), .next_addr(next_addr), .error(error),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_error(mem_error));

  leb128_fetch #(.MEM_DEPTH(6), .USE_64B(1'b0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .addr_in(addr_in), .is_signed(is_signed), .is_64(is_64),
    .busy(busy2), .done(done2), .value(value2), .length(length2), .next_addr(next_addr2), .error(error2),
    .mem_addr(mem_addr2), .mem_data(mem_data), .mem_error(mem_error));

  always @(posedge clk) begin
    mem_data <= rom[mem_addr];
    mem_error <= mem_addr >= 7'(ROM_SIZE);
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  // Decoder written as arithmetic over the byte stream: sum of 7-bit digits, subtract 2^(7n) for negatives.
  function automatic void model(input logic [6:0] a, input bit s, input bit w, output logic [63:0] v,
                                output logic [3:0] l, output logic [6:0] na, output logic [2:0] e);
    int maxb = w ? 10 : 5;
    logic [63:0] acc = 0;
    e = 0;
    l = 0;
    for (int i = 0; i < maxb; i++) begin
      logic [6:0] p = 7'(int'(a) + i);
      logic [7:0] b = rom[p];
      l = 4'(i + 1);
      if (int'(p) >= ROM_SIZE) begin e = 3; break; end
      acc = acc + (64'(b & 8'h7F) << (7 * i));
      if (b >= 8'h80) begin
        if (i == maxb - 1) e = 1;
        continue;
      end
      if (i == maxb - 1 && (w ? (s ? !(b == 8'h00 || b == 8'h7F) : b > 8'h01)
                              : (s ? !((b & 8'h78) == 8'h00 || (b & 8'h78) == 8'h78) : b > 8'h0F)))
        e = 2;
      if (s && b >= 8'h40 && 7 * (i + 1) < 64) acc = acc - (64'd1 << (7 * (i + 1)));
      break;
    end
    v = (e != 0) ? 64'd0 : w ? acc : s ? {{32{acc[31]}}, acc[31:0]} : {32'd0, acc[31:0]};
    na = 7'(int'(a) + int'(l));
  endfunction

  always @(negedge clk) begin
    if (pending) begin
      cyc++;
      if (done) begin
        chk("value", value, exp_v);
        chk("length", 64'(length), 64'(exp_l));
        chk("next_addr", 64'(next_addr), 64'(exp_na));
        chk("error", 64'(error), 64'(exp_e));
        chk("latency", 64'(cyc), 64'(exp_lat));
        pending = 0;
      end else chk("busy", 64'(busy), 64'd1);
    end else if (done) begin
      failures++;
      $display("FAIL unexpected_done actual=1 expected=0");
    end
  end

  task automatic tv(input int a, input bit s, input bit w, input logic [63:0] v, input int l, input int na, input int e);
    logic [63:0] mv;
    logic [3:0] ml;
    logic [6:0] mn;
    logic [2:0] me;
    model(7'(a), s, w, mv, ml, mn, me);
    chk($sformatf("model_value@%0d", a), mv, v);
    chk($sformatf("model_length@%0d", a), 64'(ml), 64'(l));
    chk($sformatf("model_next@%0d", a), 64'(mn), 64'(na));
    chk($sformatf("model_error@%0d", a), 64'(me), 64'(e));
    @(negedge clk); #1;
    exp_v = mv; exp_l = ml; exp_na = mn; exp_e = me; exp_lat = int'(ml) + 2;
    addr_in = 7'(a); is_signed = s; is_64 = w; start = 1; cyc = 0; pending = 1;
    @(negedge clk); #1;
    start = 0;
    for (int i = 0; i < 40 && pending; i++) begin @(negedge clk); #1; end
    if (pending) begin
      failures++;
      $display("FAIL timeout@%0d actual=no_done expected=done", a);
      pending = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    rom[0] = 8'h2A;
    rom[33] = 8'hE5; rom[34] = 8'h8E; rom[35] = 8'h26;
    rom[40] = 8'hC0; rom[41] = 8'hBB; rom[42] = 8'h78;
    rom[45] = 8'h7F;
    for (int i = 0; i < 4; i++) begin rom[50 + i] = 8'hFF; rom[56 + i] = 8'hFF; end
    rom[54] = 8'h0F; rom[60] = 8'h1F;
    for (int i = 0; i < 5; i++) rom[62 + i] = 8'h80;
    for (int i = 0; i < 9; i++) rom[70 + i] = 8'hFF;
    rom[79] = 8'h01;
    for (int i = 0; i < 4; i++) begin rom[81 + i] = 8'h80; rom[86 + i] = 8'h80; end
    rom[85] = 8'h78; rom[90] = 8'h70;
    rom[91] = 8'h3F;
    rom[98] = 8'h81; rom[99] = 8'h01;
    reset = 1; start = 0; start2 = 0; addr_in = 0; is_signed = 0; is_64 = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0); chk("rst_done", 64'(done), 0); chk("rst_value", value, 0);
    chk("rst_length", 64'(length), 0); chk("rst_next", 64'(next_addr), 0);
    chk("rst_error", 64'(error), 0); chk("rst_mem_addr", 64'(mem_addr), 0);
    #1 reset = 0;
    @(negedge clk); #1;
    addr_in = 7'd5; is_64 = 1; start2 = 1;
    @(negedge clk);
    chk("no64_done", 64'(done2), 1); chk("no64_error", 64'(error2), 4); chk("no64_value", value2, 0);
    chk("no64_length", 64'(length2), 0); chk("no64_next", 64'(next_addr2), 5);
    chk("no64_mem_addr", 64'(mem_addr2), 0); chk("no64_busy", 64'(busy2), 1);
    #1 start2 = 0;
    @(negedge clk);
    chk("no64_done_pulse", 64'(done2), 0); chk("no64_idle", 64'(busy2), 0);
    tv(0, 0, 0, 64'd42, 1, 1, 0);
    tv(33, 0, 0, 64'd624485, 3, 36, 0);
    tv(40, 1, 0, 64'hFFFF_FFFF_FFFE_1DC0, 3, 43, 0);
    tv(45, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 46, 0);
    tv(50, 0, 0, 64'h0000_0000_FFFF_FFFF, 5, 55, 0);
    tv(56, 0, 0, 64'd0, 5, 61, 2);
    tv(62, 0, 0, 64'd0, 5, 67, 1);
    tv(70, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 10, 80, 0);
    tv(70, 1, 1, 64'd0, 10, 80, 2);
    tv(70, 0, 0, 64'd0, 5, 75, 1);
    tv(81, 1, 0, 64'hFFFF_FFFF_8000_0000, 5, 86, 0);
    tv(86, 1, 0, 64'd0, 5, 91, 2);
    tv(91, 1, 0, 64'd63, 1, 92, 0);
    tv(98, 0, 0, 64'd129, 2, 100, 0);
    tv(99, 0, 0, 64'd1, 1, 100, 0);
    @(negedge clk); #1;
    addr_in = 7'd33; is_signed = 0; is_64 = 0; start = 1;
    @(negedge clk); #1 start = 0;
    @(negedge clk);
    @(negedge clk); #1 reset = 1;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 0); chk("mid_rst_done", 64'(done), 0); chk("mid_rst_value", value, 0);
    chk("mid_rst_length", 64'(length), 0); chk("mid_rst_next", 64'(next_addr), 0);
    chk("mid_rst_mem_addr", 64'(mem_addr), 0);
    #1 reset = 0;
    repeat (5) @(negedge clk);
    tv(100, 0, 0, 64'd0, 1, 101, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
